// File: rtl/ppi_mode1_port.sv
// Strobed-handshake port engine: input-latch / output-buffer handshakes with
// interrupt generation, fed by synchronized peripheral strobes and pin data.
module ppi_mode1_port #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             mode_en,
   input  logic             dir,
   input  logic             inte,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   input  logic [WIDTH-1:0] port_in,
   output logic [WIDTH-1:0] port_out,
   output logic             port_oe,
   input  logic             STB_n,
   input  logic             ACK_n,
   output logic             IBF,
   output logic             OBF_n,
   output logic             INTR,
   output logic [7:0]       status
);

   logic [SYNC_STAGES-1:0] stb_sync, ack_sync;
   logic [WIDTH-1:0]       pin_sync [SYNC_STAGES];
   logic                   stb_d, ack_d;
   logic                   stb_s, ack_s;
   logic [WIDTH-1:0]       pin_s;
   logic                   stb_fall, stb_rise, ack_fall, ack_rise;

   logic                   ibf, obf_n, intr, ovr, done, inte_q, mode_q, dir_q;
   logic [WIDTH-1:0]       in_latch, out_reg, rdata_q;
   logic                   ibf_nxt, obf_n_nxt, intr_nxt, ovr_nxt, done_nxt;
   logic [WIDTH-1:0]       in_latch_nxt, out_reg_nxt, rdata_nxt;

   // Parallel synchronizer chains keep pin data aligned with the strobe; the extra
   // flop on the strobe chains gives the edge detector its previous sample.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stb_sync <= '1;
         ack_sync <= '1;
         stb_d    <= 1'b1;
         ack_d    <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) pin_sync[i] <= '0;
      end else begin
         stb_sync <= {stb_sync[SYNC_STAGES-2:0], STB_n};
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ACK_n};
         stb_d    <= stb_sync[SYNC_STAGES-1];
         ack_d    <= ack_sync[SYNC_STAGES-1];
         pin_sync[0] <= port_in;
         for (int i = 1; i < SYNC_STAGES; i++) pin_sync[i] <= pin_sync[i-1];
      end
   end

   assign stb_s    = stb_sync[SYNC_STAGES-1];
   assign ack_s    = ack_sync[SYNC_STAGES-1];
   assign pin_s    = pin_sync[SYNC_STAGES-1];
   assign stb_fall = stb_d & ~stb_s;
   assign stb_rise = ~stb_d & stb_s;
   assign ack_fall = ack_d & ~ack_s;
   assign ack_rise = ~ack_d & ack_s;

   // Handshake next-state: later assignments in each branch take priority, so the
   // CPU access lines are applied last and win over coincident peripheral edges.
   always_comb begin
      ibf_nxt      = ibf;
      obf_n_nxt    = obf_n;
      intr_nxt     = intr;
      ovr_nxt      = ovr;
      done_nxt     = done;
      in_latch_nxt = in_latch;
      out_reg_nxt  = out_reg;
      rdata_nxt    = rdata_q;
      if (!mode_en || (mode_en != mode_q) || (dir != dir_q)) begin
         ibf_nxt   = 1'b0;
         obf_n_nxt = 1'b1;
         intr_nxt  = 1'b0;
         ovr_nxt   = 1'b0;
         done_nxt  = 1'b0;
      end else if (dir) begin
         if (stb_fall) begin
            in_latch_nxt = pin_s;
            ibf_nxt      = 1'b1;
            if (ibf && !cpu_rd) ovr_nxt = 1'b1;
         end
         if (stb_rise && inte && ibf) intr_nxt = 1'b1;
         if (inte && !inte_q && ibf && stb_s) intr_nxt = 1'b1;
         if (!inte) intr_nxt = 1'b0;
         if (cpu_rd) begin
            rdata_nxt = in_latch;
            ibf_nxt   = stb_fall;
            intr_nxt  = 1'b0;
            ovr_nxt   = 1'b0;
         end
      end else begin
         if (ack_fall) obf_n_nxt = 1'b1;
         if (ack_rise) begin
            done_nxt = 1'b1;
            if (inte && obf_n) intr_nxt = 1'b1;
         end
         if (inte && !inte_q && obf_n && ack_s && done) intr_nxt = 1'b1;
         if (!inte) intr_nxt = 1'b0;
         if (cpu_rd) rdata_nxt = out_reg;
         if (cpu_wr) begin
            out_reg_nxt = cpu_wdata;
            obf_n_nxt   = 1'b0;
            intr_nxt    = 1'b0;
            done_nxt    = 1'b0;
         end
      end
   end

   // Handshake and data registers; reset overrides everything including a live handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ibf      <= 1'b0;
         obf_n    <= 1'b1;
         intr     <= 1'b0;
         ovr      <= 1'b0;
         done     <= 1'b0;
         inte_q   <= 1'b0;
         mode_q   <= 1'b0;
         dir_q    <= 1'b0;
         in_latch <= '0;
         out_reg  <= '0;
         rdata_q  <= '0;
      end else begin
         ibf      <= ibf_nxt;
         obf_n    <= obf_n_nxt;
         intr     <= intr_nxt;
         ovr      <= ovr_nxt;
         done     <= done_nxt;
         inte_q   <= inte;
         mode_q   <= mode_en;
         dir_q    <= dir;
         in_latch <= in_latch_nxt;
         out_reg  <= out_reg_nxt;
         rdata_q  <= rdata_nxt;
      end
   end

   assign cpu_rdata = mode_en ? rdata_q : pin_s;
   assign port_out  = out_reg;
   assign port_oe   = mode_en & ~dir;
   assign IBF       = ibf;
   assign OBF_n     = obf_n;
   assign INTR      = intr;
   assign status    = {4'b0000, ovr, inte, (dir ? ibf : ~obf_n), intr};

endmodule
